// File: rtl/jane_pkg.sv
// Shared constants and types for the range-list parser.
package jane_pkg;

  // ASCII bytes recognised by the parser
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_DASH  = 8'h2D;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SP    = 8'h20;

  // Largest number of significant decimal digits in one field
  localparam int MAX_DIGITS = 12;

  typedef enum logic [2:0] {
    S_MIN,
    S_MAX,
    S_EMIT,
    S_DONE,
    S_ERR
  } state_e;

  typedef enum logic [2:0] {
    B_DIGIT,
    B_DASH,
    B_COMMA,
    B_LF,
    B_CR,
    B_SP,
    B_OTHER
  } byte_cls_e;

  // Map an input byte onto the small set of classes the FSM cares about
  function automatic byte_cls_e classify(input logic [7:0] b);
    byte_cls_e cls;
    if (b >= CH_0 && b <= CH_9) cls = B_DIGIT;
    else if (b == CH_DASH)      cls = B_DASH;
    else if (b == CH_COMMA)     cls = B_COMMA;
    else if (b == CH_LF)        cls = B_LF;
    else if (b == CH_CR)        cls = B_CR;
    else if (b == CH_SP)        cls = B_SP;
    else                        cls = B_OTHER;
    return cls;
  endfunction

endpackage

// File: rtl/range_parser_if.sv
// Byte-in / range-out handshake bundle of the range parser.
interface range_parser_if #(
  parameter int VAL_W = 40,
  parameter int LEN_W = 4
) ();

  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [VAL_W-1:0] min_val;
  logic [LEN_W-1:0] min_len;
  logic [VAL_W-1:0] max_val;
  logic [LEN_W-1:0] max_len;
  logic             out_valid;
  logic             out_ready;
  logic             done;
  logic             err;

  // Parser side
  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, min_val, min_len, max_val, max_len, out_valid, done, err
  );

  // Environment side: byte source plus range sink
  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, min_val, min_len, max_val, max_len, out_valid, done, err
  );

endinterface

// File: rtl/dec_accum.sv
// Decimal-to-binary accumulator: acc = acc*10 + digit, counting significant digits.
module dec_accum
  import jane_pkg::*;
#(
  parameter int VAL_W = 40,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             step_i,
  input  logic [3:0]       digit_i,
  output logic [VAL_W-1:0] acc_o,
  output logic [LEN_W-1:0] len_o,
  output logic             seen_o,
  output logic             ovf_o
);

  logic [VAL_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             seen_q, seen_d;
  logic [VAL_W+3:0] prod;
  logic             significant;
  logic             len_ovf;

  // Shift-add times ten plus digit, with overflow detection on the step
  always_comb begin
    prod        = ({4'd0, acc_q} << 3) + ({4'd0, acc_q} << 1) + {{VAL_W{1'b0}}, digit_i};
    significant = (acc_q != '0) || (digit_i != 4'd0);
    len_ovf     = (len_q == LEN_W'(MAX_DIGITS)) && significant;
    ovf_o       = len_ovf || (prod[VAL_W+3:VAL_W] != 4'd0);

    acc_d  = acc_q;
    len_d  = len_q;
    seen_d = seen_q;
    if (clr_i) begin
      acc_d  = '0;
      len_d  = '0;
      seen_d = 1'b0;
    end else if (step_i) begin
      acc_d  = prod[VAL_W-1:0];
      seen_d = 1'b1;
      if (significant) len_d = len_q + LEN_W'(1);
    end
  end

  // Accumulator state registers
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      len_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      len_q  <= len_d;
      seen_q <= seen_d;
    end
  end

  assign acc_o  = acc_q;
  // A field of only zeros still has one digit
  assign len_o  = (seen_q && len_q == '0) ? LEN_W'(1) : len_q;
  assign seen_o = seen_q;

endmodule

// File: rtl/range_parser.sv
// Streaming "a-b,c-d,..." parser producing binary min/max values and digit counts.
module range_parser
  import jane_pkg::*;
#(
  parameter int VAL_W = 40,
  parameter int LEN_W = 4
) (
  input logic           clk,
  input logic           rst_n,
  range_parser_if.slave bus
);

  state_e           state_q, state_d;
  byte_cls_e        cls;
  logic             is_sep;
  logic             rdy;
  logic             fire;
  logic             acc_clr, acc_step, min_load, last_load;
  logic             last_q;
  logic [VAL_W-1:0] min_val_q;
  logic [LEN_W-1:0] min_len_q;
  logic [VAL_W-1:0] acc;
  logic [LEN_W-1:0] len;
  logic             seen, ovf;

  assign cls    = classify(bus.in_data);
  assign is_sep = (cls == B_COMMA) || (cls == B_LF) || (cls == B_CR) || (cls == B_SP);
  assign fire   = bus.in_valid && rdy;

  // The accumulator holds the current field; after a range terminates it is the max value
  dec_accum #(.VAL_W(VAL_W), .LEN_W(LEN_W)) u_accum (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (acc_clr),
    .step_i  (acc_step),
    .digit_i (bus.in_data[3:0]),
    .acc_o   (acc),
    .len_o   (len),
    .seen_o  (seen),
    .ovf_o   (ovf)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_MIN;
    else        state_q <= state_d;
  end

  // Next-state decode on each accepted byte and on the output handshake
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_MIN: if (fire) begin
        if (bus.in_last) begin
          state_d = (is_sep && !seen) ? S_DONE : S_ERR;
        end else begin
          unique case (cls)
            B_DIGIT:       if (ovf) state_d = S_ERR;
            B_DASH:        state_d = seen ? S_MAX : S_ERR;
            B_COMMA, B_LF: if (seen) state_d = S_ERR;
            B_CR, B_SP:    state_d = S_MIN;
            default:       state_d = S_ERR;
          endcase
        end
      end
      S_MAX: if (fire) begin
        unique case (cls)
          B_DIGIT: begin
            if (ovf)              state_d = S_ERR;
            else if (bus.in_last) state_d = S_EMIT;
          end
          B_COMMA, B_LF:          state_d = seen ? S_EMIT : S_ERR;
          B_CR, B_SP: begin
            if (bus.in_last)      state_d = seen ? S_EMIT : S_ERR;
          end
          default:                state_d = S_ERR;
        endcase
      end
      S_EMIT: if (bus.out_ready) state_d = last_q ? S_DONE : S_MIN;
      default: state_d = state_q;
    endcase
  end

  // Handshake outputs and datapath controls derived from the current state
  always_comb begin
    rdy       = rst_n && (state_q == S_MIN || state_q == S_MAX || state_q == S_ERR);
    acc_step  = fire && (cls == B_DIGIT) && !ovf && (state_q == S_MIN || state_q == S_MAX);
    min_load  = fire && (state_q == S_MIN) && !bus.in_last && (cls == B_DASH) && seen;
    acc_clr   = min_load || (state_q == S_EMIT && bus.out_ready);
    last_load = (state_q == S_MAX) && (state_d == S_EMIT);
  end

  // Lower-bound registers and the end-of-stream marker for the pending range
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_val_q <= '0;
      min_len_q <= '0;
      last_q    <= 1'b0;
    end else begin
      if (min_load) begin
        min_val_q <= acc;
        min_len_q <= len;
      end
      if (last_load) last_q <= bus.in_last;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = (state_q == S_EMIT);
  assign bus.done      = (state_q == S_DONE);
  assign bus.err       = (state_q == S_ERR);
  assign bus.min_val   = min_val_q;
  assign bus.min_len   = min_len_q;
  assign bus.max_val   = acc;
  assign bus.max_len   = len;

endmodule

// File: tb/tb_range_parser.sv
// Scoreboard bench for range_parser: directed byte streams, queued expected ranges.
module tb_range_parser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  range_parser_if #(.VAL_W(40), .LEN_W(4)) bus ();

  range_parser #(.VAL_W(40), .LEN_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] min_val;
    logic [3:0]  min_len;
    logic [39:0] max_val;
    logic [3:0]  max_len;
  } range_t;

  range_t exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_range(input logic [39:0] mn, input logic [3:0] ml,
                              input logic [39:0] mx, input logic [3:0] xl);
    range_t r;
    r.min_val = mn; r.min_len = ml; r.max_val = mx; r.max_len = xl;
    exp_q.push_back(r);
  endtask

  // Called at a falling edge; presents one byte and returns at the falling edge after it transfers
  task automatic send(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stuck at 0 for byte %0d", b);
    end else begin
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      bus.in_last  = last;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
    end
  endtask

  task automatic send_str(input string s, input logic last_on_final);
    for (int i = 0; i < s.len(); i++)
      send(s[i], last_on_final && (i == s.len() - 1));
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_in_ready",  bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_done",      bus.done, 0);
    check("rst_err",       bus.err, 0);
    check("rst_min_val",   bus.min_val, 0);
    check("rst_min_len",   bus.min_len, 0);
    check("rst_max_val",   bus.max_val, 0);
    check("rst_max_len",   bus.max_len, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ranges_outstanding", exp_q.size(), 0);
  endtask

  // Monitor: compares every transferred range against the queue and checks held outputs
  range_t held;
  logic   hold = 1'b0;
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid",   bus.out_valid, 1);
        check("hold_min_val", bus.min_val, held.min_val);
        check("hold_max_val", bus.max_val, held.max_val);
        check("hold_lens",    {bus.min_len, bus.max_len}, {held.min_len, held.max_len});
      end
      if (bus.out_valid) check("ready_while_valid", bus.in_ready, 0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_range: got min %0d max %0d with no range expected",
                   bus.min_val, bus.max_val);
        end else begin
          range_t e;
          e = exp_q.pop_front();
          check("min_val", bus.min_val, e.min_val);
          check("min_len", bus.min_len, e.min_len);
          check("max_val", bus.max_val, e.max_val);
          check("max_len", bus.max_len, e.max_len);
        end
      end
      hold = bus.out_valid && !bus.out_ready;
      held.min_val = bus.min_val;
      held.min_len = bus.min_len;
      held.max_val = bus.max_val;
      held.max_len = bus.max_len;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);

    // Simple range, then a final newline ends the stream
    do_reset();
    expect_range(11, 2, 22, 2);
    send_str("11-22", 1'b0);
    check("s1_no_valid_early", bus.out_valid, 0);
    send(",", 1'b0);
    check("s1_latency", bus.out_valid, 1);
    send("\n", 1'b1);
    check("s1_done", bus.done, 1);
    check("s1_done_not_ready", bus.in_ready, 0);
    repeat (3) @(negedge clk);
    check("s1_no_second", bus.out_valid, 0);
    drain();

    // in_last on the final digit of the max field
    do_reset();
    expect_range(95, 2, 115, 3);
    send_str("95-115", 1'b1);
    @(negedge clk);
    check("s2_done", bus.done, 1);
    drain();

    // Downstream stall: a pending byte must wait, then transfer once
    do_reset();
    bus.out_ready = 1'b0;
    expect_range(1, 1, 9, 1);
    expect_range(2, 1, 3, 1);
    send_str("1-9,", 1'b0);
    bus.in_data  = "2";
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("s3_stall_in_ready", bus.in_ready, 0);
      check("s3_stall_valid",    bus.out_valid, 1);
      check("s3_stall_min",      bus.min_val, 1);
      check("s3_stall_max",      bus.max_val, 9);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    send("2", 1'b0);
    send_str("-3,", 1'b0);
    drain();

    // Thirteen significant digits overflow the field
    do_reset();
    send_str("123456789012", 1'b0);
    check("s4_no_err_12", bus.err, 0);
    send("3", 1'b0);
    check("s4_err", bus.err, 1);
    check("s4_drain_ready", bus.in_ready, 1);
    send_str("-5,", 1'b0);
    check("s4_err_sticky", bus.err, 1);
    check("s4_still_ready", bus.in_ready, 1);
    check("s4_no_valid", bus.out_valid, 0);
    drain();

    // Leading zeros, all-zero fields and the widest legal value
    do_reset();
    expect_range(7, 1, 10, 2);
    expect_range(0, 1, 0, 1);
    expect_range(40'd999999999999, 12, 1, 1);
    send_str("007-010,0-000,999999999999-1,", 1'b0);
    drain();
    check("s5_no_err", bus.err, 0);

    // Leading separators, min > max passed through, stray spaces ignored
    do_reset();
    expect_range(998, 3, 1012, 4);
    expect_range(5, 1, 3, 1);
    send_str("\n,998-1012,5-3 \r\n", 1'b0);
    drain();
    check("s6_no_err", bus.err, 0);

    // Separator with an empty max field is an error
    do_reset();
    send_str("4-,", 1'b0);
    check("s7_empty_max_err", bus.err, 1);

    // Reset in the middle of a field discards it
    do_reset();
    send_str("12", 1'b0);
    do_reset();
    expect_range(3, 1, 4, 1);
    send_str("3-4,", 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
